// File: rtl/tlb_refill_pkg.sv
// tlb_refill_pkg: shared widths, address types and miss-handler states for the data-side TLB.
package tlb_refill_pkg;
  localparam int ENTRIES_D = 16;
  localparam int VPN_D = 20;
  localparam int PPN_D = 8;
  localparam int OFF_D = 12;
  localparam int AGE_D = 4;
  typedef logic [VPN_D-1:0] vpn_t;
  typedef logic [PPN_D-1:0] ppn_t;
  typedef logic [VPN_D+OFF_D-1:0] vptr_t;
  typedef logic [PPN_D+OFF_D-1:0] pptr_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} tlb_state_t;
endpackage

// File: rtl/tlb_refill_lru_victim.sv
// lru_victim: picks the lowest invalid entry, else the oldest entry (lowest index on ties).
module lru_victim #(
  parameter int ENTRIES = 16,
  parameter int AGE_W = 4,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]            valid,
  input  logic [ENTRIES-1:0][AGE_W-1:0] age,
  output logic [IW-1:0]                 victim
);
  logic          inv_any;
  logic [IW-1:0] inv_idx;
  logic [IW-1:0] old_idx;
  logic [AGE_W-1:0] best;
  always_comb begin
    inv_any = 1'b0;
    inv_idx = '0;
    old_idx = '0;
    best = age[0];
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IW'(i);
      end
    for (int i = 1; i < ENTRIES; i++)
      if (age[i] > best) begin
        best = age[i];
        old_idx = IW'(i);
      end
  end
  assign victim = inv_any ? inv_idx : old_idx;
endmodule

// File: rtl/tlb_refill.sv
// tlb_refill: fully associative data TLB with supervisor bypass and page-table-walk refill FSM.
module tlb_refill import tlb_refill_pkg::*; #(
  parameter int ENTRIES = ENTRIES_D,
  parameter int VPN_W = VPN_D,
  parameter int PPN_W = PPN_D,
  parameter int OFF_W = OFF_D,
  parameter int AGE_W = AGE_D,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   lookup_valid,
  input  logic [VPN_W+OFF_W-1:0] vaddr,
  output logic [PPN_W+OFF_W-1:0] paddr,
  output logic                   hit,
  output logic                   stall,
  output logic                   fault,
  input  logic                   flush,
  output logic                   ptw_req_valid,
  input  logic                   ptw_req_ready,
  output logic [VPN_W-1:0]       ptw_req_vpn,
  input  logic                   ptw_resp_valid,
  input  logic [PPN_W-1:0]       ptw_resp_ppn,
  input  logic                   ptw_resp_fault
);
  tlb_state_t state;
  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][VPN_W-1:0] vpn;
  logic [ENTRIES-1:0][PPN_W-1:0] ppn;
  logic [ENTRIES-1:0][AGE_W-1:0] age;
  logic [PPN_W-1:0] fill_ppn;
  logic             kill;
  logic             m_any;
  logic [IW-1:0]    m_idx;
  logic [IW-1:0]    victim;
  logic [VPN_W-1:0] vpn_in;
  logic             user_hit;
  logic             user_miss;
  assign vpn_in = vaddr[OFF_W +: VPN_W];
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (valid[i] && vpn[i] == vpn_in) begin
        m_any = 1'b1;
        m_idx = IW'(i);
      end
  end
  assign user_hit = lookup_valid && !mode && state == IDLE && m_any;
  assign user_miss = lookup_valid && !mode && state == IDLE && !m_any;
  assign hit = (lookup_valid && mode) || user_hit;
  assign stall = lookup_valid && !mode && !hit;
  assign paddr = {hit ? (mode ? vaddr[OFF_W +: PPN_W] : ppn[m_idx]) : {PPN_W{1'b0}}, vaddr[OFF_W-1:0]};
  lru_victim #(.ENTRIES(ENTRIES), .AGE_W(AGE_W)) u_victim (
    .valid(valid),
    .age(age),
    .victim(victim)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      age <= '0;
      kill <= 1'b0;
      fault <= 1'b0;
      fill_ppn <= '0;
      ptw_req_valid <= 1'b0;
      ptw_req_vpn <= '0;
    end else begin
      fault <= 1'b0;
      if (user_hit)
        for (int i = 0; i < ENTRIES; i++)
          if (IW'(i) == m_idx) age[i] <= '0;
          else if (valid[i] && age[i] != {AGE_W{1'b1}}) age[i] <= age[i] + 1'b1;
      case (state)
        // The requester is dropping its access during the fault pulse, so no new walk starts then.
        IDLE: if (user_miss && !fault) begin
          ptw_req_vpn <= vpn_in;
          ptw_req_valid <= 1'b1;
          state <= REQ;
        end
        REQ: if (ptw_req_ready) begin
          ptw_req_valid <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (ptw_resp_valid) begin
          fault <= ptw_resp_fault;
          fill_ppn <= ptw_resp_ppn;
          state <= ptw_resp_fault ? IDLE : FILL;
        end
        FILL: begin
          if (!kill && !flush) begin
            valid[victim] <= 1'b1;
            vpn[victim] <= ptw_req_vpn;
            ppn[victim] <= fill_ppn;
            age[victim] <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      kill <= (state == FILL || (state == WAIT && ptw_resp_valid && ptw_resp_fault)) ? 1'b0 :
              (flush && (state == REQ || state == WAIT)) ? 1'b1 : kill;
      if (flush) valid <= '0;
    end
  end
endmodule

// File: tb/tb_tlb_refill.sv
// tb_tlb_refill: directed checks of lookup, bypass, refill, LRU, fault, flush and reset behaviour.
module tb_tlb_refill;
  logic        clk;
  logic        rst;
  logic        mode;
  logic        lookup_valid;
  logic [31:0] vaddr;
  logic [19:0] paddr;
  logic        hit;
  logic        stall;
  logic        fault;
  logic        flush;
  logic        ptw_req_valid;
  logic        ptw_req_ready;
  logic [19:0] ptw_req_vpn;
  logic        ptw_resp_valid;
  logic [7:0]  ptw_resp_ppn;
  logic        ptw_resp_fault;
  int checks = 0;
  int errors = 0;
  tlb_refill dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .lookup_valid(lookup_valid),
    .vaddr(vaddr),
    .paddr(paddr),
    .hit(hit),
    .stall(stall),
    .fault(fault),
    .flush(flush),
    .ptw_req_valid(ptw_req_valid),
    .ptw_req_ready(ptw_req_ready),
    .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid),
    .ptw_resp_ppn(ptw_resp_ppn),
    .ptw_resp_fault(ptw_resp_fault)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic fill(input logic [31:0] va, input logic [7:0] p);
    mode = 1'b0;
    lookup_valid = 1'b1;
    vaddr = va;
    #1;
    chk("fill_miss_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("fill_req_valid", {31'b0, ptw_req_valid}, 32'd1);
    chk("fill_req_vpn", {12'b0, ptw_req_vpn}, {12'b0, va[31:12]});
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn = p;
    tick();
    ptw_resp_valid = 1'b0;
    tick();
    chk("fill_hit", {31'b0, hit}, 32'd1);
    chk("fill_paddr", {12'b0, paddr}, {12'b0, p, va[11:0]});
    lookup_valid = 1'b0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; mode = 1'b0; lookup_valid = 1'b0; vaddr = '0; flush = 1'b0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_fault = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_req_valid", {31'b0, ptw_req_valid}, 32'd0);
    chk("rst_req_vpn", {12'b0, ptw_req_vpn}, 32'd0);
    chk("rst_paddr", {12'b0, paddr}, 32'd0);
    // first miss, with a supervisor bypass while waiting on the walker
    lookup_valid = 1'b1;
    vaddr = 32'h12345678;
    #1;
    chk("miss_stall", {31'b0, stall}, 32'd1);
    chk("miss_hit", {31'b0, hit}, 32'd0);
    chk("miss_req_pre", {31'b0, ptw_req_valid}, 32'd0);
    tick();
    chk("req_valid", {31'b0, ptw_req_valid}, 32'd1);
    chk("req_vpn", {12'b0, ptw_req_vpn}, 32'h12345);
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    chk("wait_req_low", {31'b0, ptw_req_valid}, 32'd0);
    mode = 1'b1;
    vaddr = 32'hABCDE123;
    #1;
    chk("sup_hit", {31'b0, hit}, 32'd1);
    chk("sup_paddr", {12'b0, paddr}, 32'hDE123);
    chk("sup_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("sup_hit2", {31'b0, hit}, 32'd1);
    mode = 1'b0;
    vaddr = 32'h12345678;
    #1;
    chk("wait_user_hit", {31'b0, hit}, 32'd0);
    chk("wait_user_stall", {31'b0, stall}, 32'd1);
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn = 8'h3C;
    tick();
    ptw_resp_valid = 1'b0;
    chk("fill_state_hit", {31'b0, hit}, 32'd0);
    tick();
    chk("refill_hit", {31'b0, hit}, 32'd1);
    chk("refill_paddr", {12'b0, paddr}, 32'h3C678);
    chk("refill_stall", {31'b0, stall}, 32'd0);
    lookup_valid = 1'b0;
    #1;
    chk("idle_hit", {31'b0, hit}, 32'd0);
    // walker not ready for five cycles
    lookup_valid = 1'b1;
    vaddr = 32'h00001000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, ptw_req_valid}, 32'd1);
      chk("hold_vpn", {12'b0, ptw_req_vpn}, 32'h00001);
      tick();
    end
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    chk("accept_low", {31'b0, ptw_req_valid}, 32'd0);
    tick();
    chk("no_dup_req", {31'b0, ptw_req_valid}, 32'd0);
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn = 8'h11;
    tick();
    ptw_resp_valid = 1'b0;
    tick();
    chk("hold_fill_hit", {31'b0, hit}, 32'd1);
    chk("hold_fill_paddr", {12'b0, paddr}, 32'h11000);
    lookup_valid = 1'b0;
    // faulting walk
    lookup_valid = 1'b1;
    vaddr = 32'h00002ABC;
    tick();
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp_fault = 1'b1;
    ptw_resp_ppn = 8'h99;
    tick();
    ptw_resp_valid = 1'b0;
    ptw_resp_fault = 1'b0;
    chk("fault_pulse", {31'b0, fault}, 32'd1);
    chk("fault_stall", {31'b0, stall}, 32'd1);
    chk("fault_hit", {31'b0, hit}, 32'd0);
    lookup_valid = 1'b0;
    tick();
    chk("fault_one_cycle", {31'b0, fault}, 32'd0);
    chk("fault_no_req", {31'b0, ptw_req_valid}, 32'd0);
    fill(32'h00002ABC, 8'h22);
    // flush while waiting for the response
    lookup_valid = 1'b1;
    vaddr = 32'h00003000;
    tick();
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn = 8'h33;
    tick();
    ptw_resp_valid = 1'b0;
    tick();
    chk("killed_hit", {31'b0, hit}, 32'd0);
    chk("killed_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("rewalk_req", {31'b0, ptw_req_valid}, 32'd1);
    chk("rewalk_vpn", {12'b0, ptw_req_vpn}, 32'h00003);
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b1;
    tick();
    ptw_resp_valid = 1'b0;
    tick();
    chk("rewalk_hit", {31'b0, hit}, 32'd1);
    chk("rewalk_paddr", {12'b0, paddr}, 32'h33000);
    vaddr = 32'h12345678;
    #1;
    chk("flushed_miss", {31'b0, stall}, 32'd1);
    // reset mid-walk, then a stray response in IDLE
    tick();
    chk("pre_rst_req", {31'b0, ptw_req_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lookup_valid = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, ptw_req_valid}, 32'd0);
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn = 8'h77;
    tick();
    ptw_resp_valid = 1'b0;
    chk("stray_resp_fault", {31'b0, fault}, 32'd0);
    lookup_valid = 1'b1;
    vaddr = 32'h00001000;
    #1;
    chk("rst_invalidated", {31'b0, stall}, 32'd1);
    lookup_valid = 1'b0;
    tick();
    // fill every entry, age entries 0..14, then replace the oldest
    for (int i = 0; i < 16; i++) fill((32'h00100 + i) << 12, 8'(i));
    for (int k = 0; k < 15; k++) begin
      lookup_valid = 1'b1;
      vaddr = (32'h00100 + k) << 12;
      #1;
      chk("age_hit", {31'b0, hit}, 32'd1);
      tick();
    end
    lookup_valid = 1'b0;
    fill(32'h00200000, 8'hAA);
    lookup_valid = 1'b1;
    vaddr = 32'h0010F000;
    #1;
    chk("lru_evicted", {31'b0, stall}, 32'd1);
    vaddr = 32'h0010E000;
    #1;
    chk("lru_kept_hit", {31'b0, hit}, 32'd1);
    chk("lru_kept_paddr", {12'b0, paddr}, 32'h0E000);
    // saturate all other ages so the lowest index wins the tie
    vaddr = 32'h00100000;
    for (int k = 0; k < 16; k++) tick();
    lookup_valid = 1'b0;
    fill(32'h00300000, 8'hBB);
    lookup_valid = 1'b1;
    vaddr = 32'h00101000;
    #1;
    chk("tie_evicted", {31'b0, stall}, 32'd1);
    vaddr = 32'h00102000;
    #1;
    chk("tie_kept_paddr", {12'b0, paddr}, 32'h02000);
    vaddr = 32'h00200000;
    #1;
    chk("tie_new_paddr", {12'b0, paddr}, 32'hAA000);
    vaddr = 32'h00100000;
    #1;
    chk("tie_young_paddr", {12'b0, paddr}, 32'h00000);
    lookup_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_refill.md
# tlb_refill

Parametrised, fully associative translation buffer with an integrated miss-handling state machine. It is the next generation of the data-side TLB. Supervisor-mode accesses bypass translation. On a user-mode miss, the block issues a page-table-walk request over a valid/ready handshake, waits for the response, refills the buffer using saturating-age LRU replacement, and reports faults. It sits between the memory stage (lookup side) and the page-table walker (refill side).

## Interface
- ENTRIES, 16, number of entries (≥2, power of two not required)
- VPN_W, 20, virtual page number width
- PPN_W, 8, physical page number width (≤ VPN_W)
- OFF_W, 12, page offset width
- AGE_W, 4, age counter width; saturates at 2^AGE_W-1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  1  1 = supervisor (bypass), 0 = user
- lookup_valid  in  1  memory stage presents vaddr this cycle
- vaddr  in  VPN_W+OFF_W  virtual address; held stable by requester while stall=1
- paddr  out  PPN_W+OFF_W  translated address; valid when hit=1
- hit  out  1  translation available this cycle
- stall  out  1  requester must hold and retry
- fault  out  1  one-cycle pulse: walker reported a fault for the pending VPN
- flush  in  1  invalidate all entries
- ptw_req_valid  out  1  walk request
- ptw_req_ready  in  1  walker accepts request
- ptw_req_vpn  out  VPN_W  VPN to walk
- ptw_resp_valid  in  1  walk response
- ptw_resp_ppn  in  PPN_W  returned PPN
- ptw_resp_fault  in  1  walk failed; no fill

## Operation
- paddr offset = vaddr offset, always.
- Supervisor (mode=1) with lookup_valid: hit=1, PPN = vaddr VPN[PPN_W-1:0], no age or state change, regardless of FSM state.
- User lookup: match = valid && vpn equal; lowest matching index wins. Match with FSM in IDLE: hit=1, paddr from entry, stall=0.
- hit=0 whenever lookup_valid=0; hit=0 for user lookups while FSM is not IDLE.
- stall = lookup_valid && !mode && !hit.
- Ages: on each user hit, the hit entry's age ← 0 and every other valid entry's age increments, saturating. There is no change on idle cycles.
- FSM states:
  - IDLE: user miss → latch VPN, go to REQ.
  - REQ: ptw_req_valid=1, ptw_req_vpn = latched VPN; on ptw_req_ready go to WAIT.
  - WAIT: on ptw_resp_valid, fault → fault pulse next cycle and go to IDLE; otherwise go to FILL.
  - FILL: write the entry unless kill is set, then go to IDLE.
- Victim selection: lowest-index invalid entry; otherwise the entry with the largest age, with ties going to the lowest index. The filled entry gets valid=1, age=0, and the other ages are unchanged.
- After FILL, the requester's held lookup hits in IDLE. Fault: the requester sees fault=1 with stall=1 and must drop the access.
- Flush:
  - Clears all valid bits at the next edge, in any state.
  - If the FSM is in REQ or WAIT, a kill bit is set. The handshake completes, the response is consumed, and FILL writes nothing.
  - Kill clears on return to IDLE.
  - Flush in the same cycle as FILL cancels that write.
- rst mid-walk: the FSM returns to IDLE and all entries are invalidated. The walker is responsible for dropping any in-flight response. A ptw_resp_valid seen in IDLE, REQ or FILL is ignored.

## Timing
- Reset values: hit=0, stall=0 (combinational), fault=0, ptw_req_valid=0, ptw_req_vpn=0, paddr PPN field=0 when no hit, all entries invalid with age 0, kill=0, state IDLE.
- Hit latency 0 cycles (combinational from vaddr).
- Miss penalty: 1 (IDLE→REQ) + request wait + 1 + response wait + 1 (FILL) + 1 hit cycle. With a walker that is always ready and responds in 0 cycles, the first hit arrives 4 cycles after the miss cycle.
- ptw_req_valid stays high and ptw_req_vpn stays stable until ready; the request is never withdrawn.
- fault is registered, high for exactly one cycle.

## Structure
- Shared package (common): vpn_t, ppn_t, vptr_t, pptr_t, and a tlb_state_t enum (IDLE, REQ, WAIT, FILL). Parameter defaults match the package widths.
- Sub-module lru_victim (combinational: valid and age vectors in, victim index out) isolates replacement for separate unit test.
- Entry storage lives in packed arrays inside tlb_refill.

## Test plan
- Reset, then user lookup of vaddr 0x12345_678 → stall=1; ptw_req_valid with ptw_req_vpn=0x12345. Respond with ppn 0x3C → 4 cycles later hit=1, paddr=0x3C_678.
- Supervisor lookup of 0xABCDE_123 in WAIT state → hit=1, paddr=0xDE_123 in the same cycle, and the FSM is undisturbed.
- Fill all 16 entries, hit entries 0–14, then miss → entry 15 (oldest) is replaced. With all ages saturated (≥16 hits elsewhere), ties resolve to the lowest index.
- ptw_req_ready held low for 5 cycles → ptw_req_valid and VPN stay stable, and no duplicate request is issued after ready.
- Response with ptw_resp_fault=1 → one-cycle fault, no entry written, and the FSM returns to IDLE. Re-lookup misses again.
- Flush asserted in WAIT → all entries invalid. The response is consumed, nothing is filled, and the same lookup misses and issues a new request.
